// File: rtl/xlr8_pinsync_pkg.sv
// xlr8_pinsync_pkg
// Shared constants and helpers for the pin synchronizer / pin-change
// interrupt block.
//   CNT_W      width of the per-bit filter counter (FILTER_LEN <= 15)
//   ARM_W      width of the post-reset arm counter (arm length <= 20)
//   arm_len()  cycles after reset release during which pulses and PCIF
//              setting are suppressed
package xlr8_pinsync_pkg;

    localparam int CNT_W = 4;
    localparam int ARM_W = 5;

    function automatic int arm_len(int sync_stages, int filter_len);
        return sync_stages + 1 + filter_len;
    endfunction

    function automatic bit sync_stages_ok(int sync_stages);
        return (sync_stages >= 2) && (sync_stages <= 4);
    endfunction

    function automatic bit filter_len_ok(int filter_len);
        return (filter_len >= 0) && (filter_len <= 15);
    endfunction

endpackage

// File: rtl/xlr8_pinsync_pcint_if.sv
// xlr8_pinsync_pcint_if
// Bundles the pad / register-file / interrupt-controller signals of one
// add-on port's input path.
//   slave  : the pin sync block (consumes pads and controls, drives PINx/PCIF)
//   master : the surrounding AVR side
interface xlr8_pinsync_pcint_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pads_in;
    logic [WIDTH-1:0] pcmsk;
    logic             pcie;
    logic             pcif_clr;
    logic             irq_ack;
    logic [WIDTH-1:0] pinx;
    logic [WIDTH-1:0] pin_rise;
    logic [WIDTH-1:0] pin_fall;
    logic             pcif;
    logic             pcint_irq;

    modport master (
        output pads_in, pcmsk, pcie, pcif_clr, irq_ack,
        input  pinx, pin_rise, pin_fall, pcif, pcint_irq
    );

    modport slave (
        input  pads_in, pcmsk, pcie, pcif_clr, irq_ack,
        output pinx, pin_rise, pin_fall, pcif, pcint_irq
    );
endinterface

// File: rtl/xlr8_pin_filter.sv
// xlr8_pin_filter
// One port bit: synchronizer chain, stability filter and registered
// rise/fall pulse generation.
//   clk, rst   core clock, synchronous active-high reset
//   pad_in     asynchronous raw pad value
//   armed      high once the post-reset suppression window has elapsed
//   pinx       synchronized, filtered pin value
//   pin_chg    combinational: pinx updates on the coming edge
//   pin_rise   one-cycle pulse after a filtered 0->1 update
//   pin_fall   one-cycle pulse after a filtered 1->0 update
module xlr8_pin_filter
    import xlr8_pinsync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    input  logic armed,
    output logic pinx,
    output logic pin_chg,
    output logic pin_rise,
    output logic pin_fall
);

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pinx_q, pinx_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_out;
    logic                   chg;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
    end

    // The counter only runs while the synchronized value disagrees with
    // pinx; any return to agreement restarts the stability window.
    always_comb begin
        cnt_d  = '0;
        pinx_d = pinx_q;
        chg    = 1'b0;
        if (sync_out != pinx_q) begin
            if (cnt_q == FILTER_LAST) begin
                pinx_d = sync_out;
                chg    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = armed & chg & sync_out;
        fall_d = armed & chg & ~sync_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            pinx_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            pinx_q <= pinx_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pinx     = pinx_q;
    assign pin_chg  = chg;
    assign pin_rise = rise_q;
    assign pin_fall = fall_q;

endmodule

// File: rtl/xlr8_pinsync_pcint.sv
// xlr8_pinsync_pcint
// Input path of one add-on port: per-bit synchronize + filter to PINx,
// per-bit edge pulses, and an AVR-style pin-change interrupt flag.
//   clk, rst  core clock, synchronous active-high reset
//   bus       slave side of xlr8_pinsync_pcint_if:
//             pads_in, pcmsk, pcie, pcif_clr, irq_ack  (in)
//             pinx, pin_rise, pin_fall, pcif, pcint_irq (out)
module xlr8_pinsync_pcint
    import xlr8_pinsync_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    xlr8_pinsync_pcint_if.slave  bus
);

    localparam int              ARM_LEN  = arm_len(SYNC_STAGES, FILTER_LEN);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_LEN);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("xlr8_pinsync_pcint: SYNC_STAGES must be in 2..4");
    end
    if (!filter_len_ok(FILTER_LEN)) begin : g_bad_filter_len
        $error("xlr8_pinsync_pcint: FILTER_LEN must be in 0..15");
    end

    logic [ARM_W-1:0] arm_q, arm_d;
    logic             pcif_q, pcif_d;
    logic             armed;
    logic             set_ev;
    logic [WIDTH-1:0] pinx_w, chg_w, rise_w, fall_w;

    // Saturating counter; the first ARM_LEN cycles after reset would
    // otherwise report the pads leaving the all-zero reset value as edges.
    assign armed = (arm_q == ARM_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xlr8_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_filter (
            .clk      (clk),
            .rst      (rst),
            .pad_in   (bus.pads_in[i]),
            .armed    (armed),
            .pinx     (pinx_w[i]),
            .pin_chg  (chg_w[i]),
            .pin_rise (rise_w[i]),
            .pin_fall (fall_w[i])
        );
    end

    assign set_ev = armed & (|(chg_w & bus.pcmsk));

    // Set has priority so a change landing on a clear is not lost.
    always_comb begin
        arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
        pcif_d = pcif_q;
        if (set_ev) begin
            pcif_d = 1'b1;
        end else if (bus.pcif_clr || bus.irq_ack) begin
            pcif_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q  <= '0;
            pcif_q <= 1'b0;
        end else begin
            arm_q  <= arm_d;
            pcif_q <= pcif_d;
        end
    end

    assign bus.pinx      = pinx_w;
    assign bus.pin_rise  = rise_w;
    assign bus.pin_fall  = fall_w;
    assign bus.pcif      = pcif_q;
    assign bus.pcint_irq = pcif_q & bus.pcie;

endmodule
